// File: rtl/riscv_alu_param.sv
// rtl/riscv_alu_param.sv - parametrised RI5CY EX-stage ALU; RISCV_ALU_PARAM_DIV_EN adds an iterative radix-2 divider
module riscv_alu_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH),
    localparam int ALU_OP_WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [ALU_OP_WIDTH-1:0] operator_i,
    input  logic [WIDTH-1:0]        operand_a_i,
    input  logic [WIDTH-1:0]        operand_b_i,
    input  logic [2:0]              vector_mode_i,
    output logic [WIDTH-1:0]        result_o,
    output logic                    comparison_result_o,
    output logic                    ready_o,
    input  logic                    ex_ready_i
);

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD   = 7'b0011000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB   = 7'b0011001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR   = 7'b0101111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR    = 7'b0101110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND   = 7'b0010101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA   = 7'b0100100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL   = 7'b0100101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL   = 7'b0100111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS   = 7'b0000000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU   = 7'b0000001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS  = 7'b0000010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU  = 7'b0000011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LES   = 7'b0000100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LEU   = 7'b0000101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLETS = 7'b0000110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLETU = 7'b0000111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GTS   = 7'b0001000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GTU   = 7'b0001001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GES   = 7'b0001010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU   = 7'b0001011;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ    = 7'b0001100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NE    = 7'b0001101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU  = 7'b0110000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV   = 7'b0110001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU  = 7'b0110010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_REM   = 7'b0110011;

    localparam logic [2:0] VEC_MODE16 = 3'b010;
    localparam logic [2:0] VEC_MODE8  = 3'b011;

    localparam logic [2:0] K_EQ = 3'd0;
    localparam logic [2:0] K_NE = 3'd1;
    localparam logic [2:0] K_GT = 3'd2;
    localparam logic [2:0] K_GE = 3'd3;
    localparam logic [2:0] K_LT = 3'd4;
    localparam logic [2:0] K_LE = 3'd5;

    localparam int L8  = WIDTH / 8;
    localparam int L16 = WIDTH / 16;

    function automatic logic lane_pick(input logic [2:0] kind, input logic gt, input logic eq);
        case (kind)
            K_EQ:    return eq;
            K_NE:    return !eq;
            K_GT:    return gt;
            K_GE:    return gt | eq;
            K_LT:    return !(gt | eq);
            default: return !gt;
        endcase
    endfunction

    logic [CNT_W-1:0] shamt;
    logic             cmp_signed;
    logic             scalar_only;
    logic [2:0]       cmp_kind;
    logic [WIDTH-1:0] res8, res16, res_s, cmp_vec, comb_result;
    logic [L8-1:0]    bit8;
    logic [L16-1:0]   bit16;
    logic             bit_s, cmp_top;

    assign shamt = operand_b_i[CNT_W-1:0];

    always_comb begin
        cmp_signed  = 1'b0;
        scalar_only = 1'b0;
        cmp_kind    = K_EQ;
        case (operator_i)
            ALU_NE:    cmp_kind = K_NE;
            ALU_GTS:   begin cmp_kind = K_GT; cmp_signed = 1'b1; end
            ALU_GTU:   cmp_kind = K_GT;
            ALU_GES:   begin cmp_kind = K_GE; cmp_signed = 1'b1; end
            ALU_GEU:   cmp_kind = K_GE;
            ALU_LTS:   begin cmp_kind = K_LT; cmp_signed = 1'b1; end
            ALU_LTU:   cmp_kind = K_LT;
            ALU_LES:   begin cmp_kind = K_LE; cmp_signed = 1'b1; end
            ALU_LEU:   cmp_kind = K_LE;
            ALU_SLTS:  begin cmp_kind = K_LT; cmp_signed = 1'b1; scalar_only = 1'b1; end
            ALU_SLTU:  begin cmp_kind = K_LT; scalar_only = 1'b1; end
            ALU_SLETS: begin cmp_kind = K_LE; cmp_signed = 1'b1; scalar_only = 1'b1; end
            ALU_SLETU: begin cmp_kind = K_LE; scalar_only = 1'b1; end
            default:   cmp_kind = K_EQ;
        endcase
    end

    // Each lane is widened by one bit so signed and unsigned share one comparator.
    for (genvar i = 0; i < L8; i++) begin : g_lane8
        logic signed [8:0] a_x, b_x;
        assign a_x = {cmp_signed & operand_a_i[8*i+7], operand_a_i[8*i +: 8]};
        assign b_x = {cmp_signed & operand_b_i[8*i+7], operand_b_i[8*i +: 8]};
        assign bit8[i] = lane_pick(cmp_kind, a_x > b_x, a_x == b_x);
        assign res8[8*i +: 8] = {8{bit8[i]}};
    end

    for (genvar i = 0; i < L16; i++) begin : g_lane16
        logic signed [16:0] a_x, b_x;
        assign a_x = {cmp_signed & operand_a_i[16*i+15], operand_a_i[16*i +: 16]};
        assign b_x = {cmp_signed & operand_b_i[16*i+15], operand_b_i[16*i +: 16]};
        assign bit16[i] = lane_pick(cmp_kind, a_x > b_x, a_x == b_x);
        assign res16[16*i +: 16] = {16{bit16[i]}};
    end

    logic signed [WIDTH:0] a_s, b_s;
    assign a_s   = {cmp_signed & operand_a_i[WIDTH-1], operand_a_i};
    assign b_s   = {cmp_signed & operand_b_i[WIDTH-1], operand_b_i};
    assign bit_s = lane_pick(cmp_kind, a_s > b_s, a_s == b_s);
    assign res_s = {WIDTH{bit_s}};

    always_comb begin
        cmp_vec = res_s;
        cmp_top = bit_s;
        if (!scalar_only && vector_mode_i == VEC_MODE8) begin
            cmp_vec = res8;
            cmp_top = bit8[L8-1];
        end else if (!scalar_only && vector_mode_i == VEC_MODE16) begin
            cmp_vec = res16;
            cmp_top = bit16[L16-1];
        end
    end

    always_comb begin
        comb_result = '0;
        case (operator_i)
            ALU_AND: comb_result = operand_a_i & operand_b_i;
            ALU_OR:  comb_result = operand_a_i | operand_b_i;
            ALU_XOR: comb_result = operand_a_i ^ operand_b_i;
            ALU_ADD: comb_result = operand_a_i + operand_b_i;
            ALU_SUB: comb_result = operand_a_i - operand_b_i;
            ALU_SLL: comb_result = operand_a_i << shamt;
            ALU_SRL: comb_result = operand_a_i >> shamt;
            ALU_SRA: comb_result = $signed(operand_a_i) >>> shamt;
            ALU_EQ, ALU_NE, ALU_GTS, ALU_GTU, ALU_GES, ALU_GEU,
            ALU_LTS, ALU_LTU, ALU_LES, ALU_LEU:
                comb_result = cmp_vec;
            ALU_SLTS, ALU_SLTU, ALU_SLETS, ALU_SLETU:
                comb_result = {{(WIDTH-1){1'b0}}, cmp_top};
            default: comb_result = '0;
        endcase
    end

    assign comparison_result_o = cmp_top;

`ifdef RISCV_ALU_PARAM_DIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic             is_rem_q, is_rem_d, quot_neg_q, quot_neg_d, rem_neg_q, rem_neg_d;

    logic             div_op, div_signed, op_rem, a_neg, b_neg, div_zero, div_ovf;
    logic [WIDTH-1:0] abs_a, abs_b, rem_shift, quot_fix, rem_fix;
    logic [WIDTH:0]   step_diff;

    assign div_op     = operator_i inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    assign div_signed = (operator_i == ALU_DIV) || (operator_i == ALU_REM);
    assign op_rem     = (operator_i == ALU_REM) || (operator_i == ALU_REMU);
    assign a_neg      = div_signed & operand_a_i[WIDTH-1];
    assign b_neg      = div_signed & operand_b_i[WIDTH-1];
    assign abs_a      = a_neg ? -operand_a_i : operand_a_i;
    assign abs_b      = b_neg ? -operand_b_i : operand_b_i;
    assign div_zero   = (operand_b_i == '0);
    assign div_ovf    = div_signed && (operand_a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (&operand_b_i);

    // Dividend bits shift out of quot_q's MSB into the partial remainder as quotient bits shift in.
    assign rem_shift = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
    assign step_diff = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvsr_q};
    assign quot_fix  = quot_neg_q ? -quot_q : quot_q;
    assign rem_fix   = rem_neg_q ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dvsr_q     <= '0;
            is_rem_q   <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dvsr_q     <= dvsr_d;
            is_rem_q   <= is_rem_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dvsr_d     = dvsr_q;
        is_rem_d   = is_rem_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        result_o   = comb_result;
        ready_o    = 1'b1;
        case (state_q)
            IDLE: begin
                ready_o = !(enable_i && div_op);
                if (enable_i && div_op) begin
                    is_rem_d   = op_rem;
                    quot_neg_d = 1'b0;
                    rem_neg_d  = 1'b0;
                    dvsr_d     = '0;
                    if (div_zero) begin
                        quot_d  = '1;
                        rem_d   = operand_a_i;
                        state_d = DONE;
                    end else if (div_ovf) begin
                        quot_d  = operand_a_i;
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        quot_d     = abs_a;
                        rem_d      = '0;
                        dvsr_d     = abs_b;
                        quot_neg_d = a_neg ^ b_neg;
                        rem_neg_d  = a_neg;
                        cnt_d      = CNT_W'(WIDTH - 1);
                        state_d    = BUSY;
                    end
                end
            end
            BUSY: begin
                ready_o  = 1'b0;
                result_o = '0;
                if (!step_diff[WIDTH]) begin
                    rem_d  = step_diff[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift;
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            DONE: begin
                result_o = is_rem_q ? rem_fix : quot_fix;
                if (ex_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
`else
    logic unused_div_ports;
    assign unused_div_ports = &{1'b0, clk, rst_n, enable_i, ex_ready_i};
    assign result_o = comb_result;
    assign ready_o  = 1'b1;
`endif

endmodule

// File: tb/tb_riscv_alu_param.sv
// tb/tb_riscv_alu_param.sv - scoreboard bench for riscv_alu_param at WIDTH=32
module tb_riscv_alu_param;

    localparam logic [6:0] ALU_ADD   = 7'b0011000;
    localparam logic [6:0] ALU_SUB   = 7'b0011001;
    localparam logic [6:0] ALU_XOR   = 7'b0101111;
    localparam logic [6:0] ALU_AND   = 7'b0010101;
    localparam logic [6:0] ALU_SRA   = 7'b0100100;
    localparam logic [6:0] ALU_SRL   = 7'b0100101;
    localparam logic [6:0] ALU_SLL   = 7'b0100111;
    localparam logic [6:0] ALU_SLTS  = 7'b0000010;
    localparam logic [6:0] ALU_SLTU  = 7'b0000011;
    localparam logic [6:0] ALU_SLETS = 7'b0000110;
    localparam logic [6:0] ALU_GTS   = 7'b0001000;
    localparam logic [6:0] ALU_LTU   = 7'b0000001;
    localparam logic [6:0] ALU_EQ    = 7'b0001100;
    localparam logic [6:0] ALU_DIVU  = 7'b0110000;
    localparam logic [6:0] ALU_DIV   = 7'b0110001;
    localparam logic [6:0] ALU_REMU  = 7'b0110010;
    localparam logic [6:0] ALU_REM   = 7'b0110011;
    localparam logic [2:0] SCALAR    = 3'b000;
    localparam logic [2:0] VEC16     = 3'b010;
    localparam logic [2:0] VEC8      = 3'b011;

`ifdef RISCV_ALU_PARAM_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam int DLAT = DIV_ON ? 33 : 0;
    localparam int SLAT = DIV_ON ? 1 : 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable_i = 1'b0;
    logic [6:0]  operator_i = ALU_AND;
    logic [31:0] operand_a_i = '0;
    logic [31:0] operand_b_i = '0;
    logic [2:0]  vector_mode_i = SCALAR;
    logic [31:0] result_o;
    logic        comparison_result_o;
    logic        ready_o;
    logic        ex_ready_i = 1'b1;

    riscv_alu_param #(.WIDTH(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable_i            (enable_i),
        .operator_i          (operator_i),
        .operand_a_i         (operand_a_i),
        .operand_b_i         (operand_b_i),
        .vector_mode_i       (vector_mode_i),
        .result_o            (result_o),
        .comparison_result_o (comparison_result_o),
        .ready_o             (ready_o),
        .ex_ready_i          (ex_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        cmp;
        bit          chk_cmp;
        int          low;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   low_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Monitor: pops one expectation per cycle in which the DUT reports ready.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            if (ready_o) begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "/res"}, result_o, mon_e.res);
                chk({mon_e.name, "/low"}, low_cnt, mon_e.low);
                if (mon_e.chk_cmp) chk({mon_e.name, "/cmp"}, {31'b0, comparison_result_o}, {31'b0, mon_e.cmp});
                low_cnt = 0;
            end else begin
                low_cnt++;
                if (low_cnt > 200) begin
                    mon_e = sb.pop_front();
                    total++;
                    bad++;
                    $display("FAIL %s/timeout: ready low %0d cycles, want %0d", mon_e.name, low_cnt, mon_e.low);
                    low_cnt = 0;
                end
            end
        end
    end

    task automatic push(input logic [31:0] res, input logic cmp, input bit chk_cmp, input int low, input string name);
        exp_t e;
        e.res = res; e.cmp = cmp; e.chk_cmp = chk_cmp; e.low = low; e.name = name;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (sb.size() != 0 && n < 400);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b, input logic [2:0] mode,
                         input logic [31:0] res, input logic cmp, input bit chk_cmp, input int low,
                         input int reps, input string name);
        @(posedge clk); #1;
        operator_i = op; operand_a_i = a; operand_b_i = b; vector_mode_i = mode; enable_i = 1'b1;
        push(res, cmp, chk_cmp, low, name);
        for (int i = 1; i < reps; i++) push(res, cmp, chk_cmp, 0, $sformatf("%s_hold%0d", name, i));
        drain();
        enable_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        issue(ALU_AND, 32'h0000F0F0, 32'h0000FF00, SCALAR, 32'h0000F000, 1'b0, 1'b0, 0, 1, "reset_and");
        @(negedge clk); rst_n = 1'b1;

        issue(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, SCALAR, 32'h80000000, 1'b0, 1'b0, 0, 1, "add_ovf");
        issue(ALU_SUB, 32'h00000000, 32'h00000001, SCALAR, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 1, "sub_wrap");
        issue(ALU_XOR, 32'hA5A5A5A5, 32'hFFFF0000, SCALAR, 32'h5A5AA5A5, 1'b0, 1'b0, 0, 1, "xor");
        issue(ALU_SLL, 32'h00000001, 32'h00000021, SCALAR, 32'h00000002, 1'b0, 1'b0, 0, 1, "sll_mask");
        issue(ALU_SRA, 32'h80000000, 32'h00000004, SCALAR, 32'hF8000000, 1'b0, 1'b0, 0, 1, "sra");
        issue(ALU_SRL, 32'h80000000, 32'h0000001F, SCALAR, 32'h00000001, 1'b0, 1'b0, 0, 1, "srl");
        issue(ALU_GTS, 32'h80000001, 32'h7FFF0000, VEC16,  32'h0000FFFF, 1'b0, 1'b1, 0, 1, "gts_v16");
        issue(ALU_EQ,  32'h11223344, 32'h11003344, VEC8,   32'hFF00FFFF, 1'b1, 1'b1, 0, 1, "eq_v8");
        issue(ALU_LTU, 32'h00000001, 32'hFFFFFFFF, SCALAR, 32'hFFFFFFFF, 1'b1, 1'b1, 0, 1, "ltu");
        issue(ALU_SLTS, 32'hFFFFFFFF, 32'h00000001, SCALAR, 32'h00000001, 1'b1, 1'b1, 0, 1, "slts");
        issue(ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, SCALAR, 32'h00000000, 1'b0, 1'b1, 0, 1, "sltu");
        issue(ALU_SLETS, 32'h01FF0000, 32'h01000000, VEC8, 32'h00000000, 1'b0, 1'b1, 0, 1, "slets_scalar");
        issue(7'b1111111, 32'h12345678, 32'h9ABCDEF0, SCALAR, 32'h00000000, 1'b0, 1'b0, 0, 1, "unsupported");

        issue(ALU_DIV,  32'hFFFFFFF9, 32'h00000002, SCALAR, DIV_ON ? 32'hFFFFFFFD : 32'h0, 1'b0, 1'b0, DLAT, 1, "div_neg");
        issue(ALU_REM,  32'hFFFFFFF9, 32'h00000002, SCALAR, DIV_ON ? 32'hFFFFFFFF : 32'h0, 1'b0, 1'b0, DLAT, 1, "rem_neg");
        issue(ALU_DIVU, 32'd100, 32'd0, SCALAR, DIV_ON ? 32'hFFFFFFFF : 32'h0, 1'b0, 1'b0, SLAT, 1, "divu_zero");
        issue(ALU_REMU, 32'd100, 32'd0, SCALAR, DIV_ON ? 32'd100 : 32'h0, 1'b0, 1'b0, SLAT, 1, "remu_zero");
        issue(ALU_DIV,  32'h80000000, 32'hFFFFFFFF, SCALAR, DIV_ON ? 32'h80000000 : 32'h0, 1'b0, 1'b0, SLAT, 1, "div_ovf");
        issue(ALU_REM,  32'h80000000, 32'hFFFFFFFF, SCALAR, 32'h0, 1'b0, 1'b0, SLAT, 1, "rem_ovf");
        issue(ALU_DIVU, 32'd100, 32'd7, SCALAR, DIV_ON ? 32'd14 : 32'h0, 1'b0, 1'b0, DLAT, 1, "divu");
        issue(ALU_REMU, 32'd100, 32'd7, SCALAR, DIV_ON ? 32'd2 : 32'h0, 1'b0, 1'b0, DLAT, 1, "remu");

        ex_ready_i = 1'b0;
        issue(ALU_DIV, 32'hFFFFFFF9, 32'h00000002, SCALAR, DIV_ON ? 32'hFFFFFFFD : 32'h0, 1'b0, 1'b0, DLAT, 6, "stall");
        ex_ready_i = 1'b1;

        @(posedge clk); #1;
        operator_i = ALU_DIV; operand_a_i = 32'hFFFFFFF9; operand_b_i = 32'h2; enable_i = 1'b1;
        @(posedge clk); #1;
        enable_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        operator_i = ALU_AND; operand_a_i = 32'h0F0F0F0F; operand_b_i = 32'h00FF00FF;
        push(32'h000F000F, 1'b0, 1'b0, 0, "rst_mid_busy");
        drain();
        rst_n = 1'b1;
        issue(ALU_DIVU, 32'd100, 32'd7, SCALAR, DIV_ON ? 32'd14 : 32'h0, 1'b0, 1'b0, DLAT, 1, "after_rst");

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_alu_param.md
# riscv_alu_param

Parametrised successor of the basic shared-DSP ALU for the RI5CY EX stage. It has the same single-cycle logic, add/sub, shift and vector-compare operators, generalised to any `WIDTH` that is a multiple of 16. It adds an iterative radix-2 divider for `ALU_DIV`, `ALU_DIVU`, `ALU_REM` and `ALU_REMU`, which stalls EX through the `ready_o`/`ex_ready_i` handshake. It sits in place of the basic ALU in the EX stage; operator codes are the `ALU_*` encodings from `riscv_defines`.

## Interface
- `WIDTH`, default 32: datapath width; a multiple of 16 and ≥ 16.
- `CNT_W`, default `$clog2(WIDTH)`: iteration counter and shift-amount width.
- `clk` in 1: clock. One clock domain; the block has only this clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `enable_i` in 1: an operation is presented this cycle.
- `operator_i` in `ALU_OP_WIDTH`: operation code (`riscv_defines`).
- `operand_a_i` in `WIDTH`: operand A (dividend for divide operations).
- `operand_b_i` in `WIDTH`: operand B (divisor; shift amount).
- `vector_mode_i` in 3: `VEC_MODE8`, `VEC_MODE16`, anything else = scalar.
- `result_o` out `WIDTH`: result.
- `comparison_result_o` out 1: comparison result of the most significant lane.
- `ready_o` out 1: the result is valid and EX may advance.
- `ex_ready_i` in 1: EX stage consumes the result this cycle.

## Operation
- Single-cycle operators are purely combinational from the inputs, with `ready_o` = 1:
  - `AND`/`OR`/`XOR`.
  - `ADD`/`SUB`: modulo 2^WIDTH.
  - `SLL`/`SRL`/`SRA`: shift amount is `operand_b_i[CNT_W-1:0]`.
- Comparisons (`EQ`, `NE`, `GT*`, `GE*`, `LT*`, `LE*`):
  - Computed per lane; lanes are 8-bit (`VEC_MODE8`), 16-bit (`VEC_MODE16`) or `WIDTH`-bit (scalar).
  - Signed forms sign-extend each lane's MSB.
  - Each lane's result is replicated across that lane in `result_o`.
  - `SLTS`/`SLTU`/`SLETS`/`SLETU` return `{0…0, comparison_result_o}` and always use scalar mode.
- Unsupported operators: `result_o` = 0, `ready_o` = 1.
- Divider FSM, states `IDLE`, `BUSY`, `DONE`:
  - **IDLE → BUSY**: `enable_i` with a divide operator, divisor ≠ 0, and not a signed overflow. The block latches |A|, |B|, the operator, `sign_q` = A[MSB]^B[MSB] (signed only) and `sign_r` = A[MSB] (signed only). The counter loads `WIDTH`-1. `ready_o` = 0.
  - **IDLE → DONE** (special cases, no iterations):
    - Divisor = 0: quotient = all ones; remainder = A.
    - Signed `DIV`/`REM` with A = 100…0 and B = all ones: quotient = A; remainder = 0.
  - **BUSY**: one restoring shift-subtract step per cycle, `ready_o` = 0. When the counter reaches 0, go to DONE.
  - **DONE**: `result_o` is the sign-corrected quotient or remainder from the latched state; the quotient is negated if `sign_q`, the remainder is negated if `sign_r`. `ready_o` = 1. Go to IDLE when `ex_ready_i` = 1; otherwise hold with `result_o` stable.
- While in BUSY or DONE, `operator_i`, `operand_*_i` and `enable_i` are ignored; the latched values are used.
- In IDLE without `enable_i`, the divider does not start, and `result_o`/`comparison_result_o` follow the combinational path.

## Timing
- Reset values (`rst_n` low, any time, including mid-BUSY):
  - State = IDLE, counter = 0, latched registers = 0.
  - `ready_o` = 1 unless `enable_i` with a divide operator is presented.
  - `result_o` and `comparison_result_o` follow the combinational path.
  - An aborted divide produces no result.
- Single-cycle operators: latency 0.
- Normal divide, accepted in cycle 0:
  - `ready_o` is low in cycles 0 … `WIDTH` (`WIDTH`+1 cycles).
  - The result is valid in cycle `WIDTH`+1.
- Special-case divide: `ready_o` is low in cycle 0 only; the result is valid in cycle 1.
- Back-to-back divides: after DONE → IDLE on `ex_ready_i`, the next divide may be accepted in the following cycle.

## Configuration
- `RISCV_ALU_PARAM_DIV_EN`
  - Defined: the divider FSM and datapath are compiled in, as described above.
  - Undefined: no divider registers exist. Divide operators are unsupported: `result_o` = 0, `ready_o` = 1, and the block is purely combinational apart from the unused reset.

## Test plan
All vectors use `WIDTH` = 32 with `RISCV_ALU_PARAM_DIV_EN` defined.
1. **ADD overflow.** `ADD` A = 0x7FFFFFFF, B = 1 → `result_o` = 0x80000000 in the same cycle, `ready_o` = 1.
2. **Vector compare.** `GTS`, `VEC_MODE16`, A = 0x80000001, B = 0x7FFF0000 → `result_o` = 0x0000FFFF, `comparison_result_o` = 0.
3. **Signed divide.**
   - `DIV` A = 0xFFFFFFF9 (−7), B = 2 → `ready_o` low 33 cycles, then `result_o` = 0xFFFFFFFD.
   - `REM` with the same operands → 0xFFFFFFFF.
4. **Divide by zero.**
   - `DIVU` A = 100, B = 0 → `ready_o` low 1 cycle, then `result_o` = 0xFFFFFFFF.
   - `REMU` A = 100, B = 0 → 100.
5. **Signed overflow.**
   - `DIV` A = 0x80000000, B = 0xFFFFFFFF → `result_o` = 0x80000000.
   - `REM` with the same operands → 0.
6. **Stall and reset.**
   - Hold `ex_ready_i` = 0 for 5 cycles in DONE → `result_o` stable and `ready_o` = 1 throughout.
   - Assert `rst_n` low mid-BUSY → `ready_o` = 1 immediately; the next divide runs the full 33-cycle latency.
